// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the 8-bit single-cycle datapath.
// It holds the program memory and the PC, and drives the register file write port.
module fetch_decode_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Prog_We,
  input  logic [ADDR_W-1:0] Prog_Addr,
  input  logic [7:0]        Prog_Data,
  input  logic              Start,
  input  logic [7:0]        Read_Data,
  output logic [2:0]        RD,
  output logic [7:0]        Write_Data,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic [7:0]        Instr_Count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        count_q, count_d;

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] instr;
  logic [1:0] op;
  logic [2:0] imm3;
  logic       mem_we;
  logic       retire;

  assign instr  = mem[pc_q];
  assign op     = instr[7:6];
  assign imm3   = instr[2:0];
  assign mem_we = (state_q == ST_IDLE) && Prog_We;

  // Program memory keeps its contents across reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[Prog_Addr] <= Prog_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retire     = 1'b0;
    RD         = 3'd0;
    Write_Data = 8'd0;
    Reg_Write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        case (op)
          OP_LDI: begin
            Reg_Write  = 1'b1;
            RD         = instr[5:3];
            Write_Data = {5'b0, imm3};
            pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            retire     = 1'b1;
          end
          OP_ADDI: begin
            Reg_Write  = 1'b1;
            RD         = instr[5:3];
            Write_Data = Read_Data + {{5{imm3[2]}}, imm3};
            pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            retire     = 1'b1;
          end
          OP_JMP: begin
            pc_d   = instr[ADDR_W-1:0];
            retire = 1'b1;
          end
          default: begin
            // HALT parks with PC still pointing at the HALT word.
            state_d = ST_HALT;
          end
        endcase
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    count_d = count_q;
    if (retire && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  assign PC          = pc_q;
  assign Busy        = (state_q == ST_RUN);
  assign Halted      = (state_q == ST_HALT);
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with a small behavioural register file
// that answers Read_Data for the currently driven RD.
module tb_fetch_decode_unit;

  localparam int ADDR_W = 5;

  logic              Clk;
  logic              Reset;
  logic              Prog_We;
  logic [ADDR_W-1:0] Prog_Addr;
  logic [7:0]        Prog_Data;
  logic              Start;
  logic [7:0]        Read_Data;
  logic [2:0]        RD;
  logic [7:0]        Write_Data;
  logic              Reg_Write;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic [7:0]        Instr_Count;

  int tests_run;
  int tests_failed;

  logic [7:0] rf [8];

  fetch_decode_unit #(.ADDR_W(ADDR_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Prog_We     (Prog_We),
    .Prog_Addr   (Prog_Addr),
    .Prog_Data   (Prog_Data),
    .Start       (Start),
    .Read_Data   (Read_Data),
    .RD          (RD),
    .Write_Data  (Write_Data),
    .Reg_Write   (Reg_Write),
    .PC          (PC),
    .Busy        (Busy),
    .Halted      (Halted),
    .Instr_Count (Instr_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  end

  always_comb Read_Data = rf[RD];

  always @(posedge Clk) begin
    if (Reg_Write) rf[RD] <= Write_Data;
  end

  // Advance one edge; inputs are driven and outputs sampled 2 time units later.
  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    cyc();
    Reset = 1'b1;
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    Prog_We   = 1'b1;
    Prog_Addr = a;
    Prog_Data = d;
    cyc();
    Prog_We = 1'b0;
    #1;
  endtask

  task automatic start_run();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    #1;
  endtask

  task automatic chk_wr(input string name, input logic we, input logic [2:0] rd,
                        input logic [7:0] wd, input logic [ADDR_W-1:0] pc);
    tests_run++;
    if (Reg_Write !== we || RD !== rd || Write_Data !== wd || PC !== pc) begin
      tests_failed++;
      $display("FAIL %s: got we=%0b rd=%0d wd=%02h pc=%0d, want we=%0b rd=%0d wd=%02h pc=%0d",
               name, Reg_Write, RD, Write_Data, PC, we, rd, wd, pc);
    end else begin
      $display("ok   %s: we=%0b rd=%0d wd=%02h pc=%0d", name, Reg_Write, RD, Write_Data, PC);
    end
  endtask

  task automatic chk_st(input string name, input logic busy, input logic halted,
                        input logic [ADDR_W-1:0] pc, input logic [7:0] cnt);
    tests_run++;
    if (Busy !== busy || Halted !== halted || PC !== pc || Instr_Count !== cnt) begin
      tests_failed++;
      $display("FAIL %s: got busy=%0b halted=%0b pc=%0d cnt=%0d, want busy=%0b halted=%0b pc=%0d cnt=%0d",
               name, Busy, Halted, PC, Instr_Count, busy, halted, pc, cnt);
    end else begin
      $display("ok   %s: busy=%0b halted=%0b pc=%0d cnt=%0d", name, Busy, Halted, PC, Instr_Count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_wr("reset_wr", 1'b0, 3'd0, 8'h00, 5'd0);
    chk_st("reset_st", 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_ldi_halt();
    do_reset();
    load(5'd0, 8'h0D);
    load(5'd1, 8'h0D);
    load(5'd2, 8'hC0);
    start_run();
    chk_wr("ldi_c0", 1'b1, 3'd1, 8'h05, 5'd0);
    cyc();
    chk_wr("ldi_c1", 1'b1, 3'd1, 8'h05, 5'd1);
    cyc();
    chk_wr("halt_fetch", 1'b0, 3'd0, 8'h00, 5'd2);
    cyc();
    chk_st("halted", 1'b0, 1'b1, 5'd2, 8'd2);
    // Start and Prog_We must be ignored while halted.
    Prog_We = 1'b1; Prog_Addr = 5'd0; Prog_Data = 8'hC0; Start = 1'b1;
    cyc();
    Prog_We = 1'b0; Start = 1'b0;
    cyc();
    chk_st("halt_hold", 1'b0, 1'b1, 5'd2, 8'd2);
    do_reset();
    start_run();
    chk_wr("halt_mem_kept", 1'b1, 3'd1, 8'h05, 5'd0);
  endtask

  task automatic test_addi_wrap();
    do_reset();
    load(5'd0, 8'h10);
    load(5'd1, 8'h57);
    load(5'd2, 8'h51);
    load(5'd3, 8'hC0);
    start_run();
    chk_wr("ldi_r2_0", 1'b1, 3'd2, 8'h00, 5'd0);
    cyc();
    chk_wr("addi_m1", 1'b1, 3'd2, 8'hFF, 5'd1);
    cyc();
    chk_wr("addi_p1", 1'b1, 3'd2, 8'h00, 5'd2);
    cyc();
    chk_wr("addi_halt", 1'b0, 3'd0, 8'h00, 5'd3);
    cyc();
    chk_st("addi_done", 1'b0, 1'b1, 5'd3, 8'd3);
  endtask

  task automatic test_jmp();
    do_reset();
    load(5'd0, 8'h83);
    load(5'd3, 8'hC0);
    start_run();
    chk_wr("jmp_c0", 1'b0, 3'd0, 8'h00, 5'd0);
    cyc();
    chk_wr("jmp_c1", 1'b0, 3'd0, 8'h00, 5'd3);
    cyc();
    chk_st("jmp_done", 1'b0, 1'b1, 5'd3, 8'd1);
  endtask

  task automatic test_wrap_saturate_reset();
    int bad;
    int exp_cnt;
    do_reset();
    for (int a = 0; a < 32; a++) load(a[ADDR_W-1:0], 8'h0D);
    start_run();
    bad = 0;
    for (int i = 0; i <= 327; i++) begin
      exp_cnt = (i > 255) ? 255 : i;
      tests_run++;
      if (PC !== i[ADDR_W-1:0] || Instr_Count !== exp_cnt[7:0] || Busy !== 1'b1) begin
        tests_failed++;
        bad++;
        if (bad <= 4)
          $display("FAIL wrap_cyc%0d: got pc=%0d cnt=%0d busy=%0b, want pc=%0d cnt=%0d busy=1",
                   i, PC, Instr_Count, Busy, i % 32, exp_cnt);
      end
      if (i == 31 || i == 32 || i == 255 || i == 256 || i == 327)
        $display("ok?  wrap_cyc%0d: pc=%0d cnt=%0d", i, PC, Instr_Count);
      if (i != 327) cyc();
    end
    // Now at PC=7 mid-RUN: one reset edge.
    do_reset();
    chk_wr("midrun_rst_wr", 1'b0, 3'd0, 8'h00, 5'd0);
    chk_st("midrun_rst_st", 1'b0, 1'b0, 5'd0, 8'd0);
    start_run();
    chk_wr("midrun_mem_kept", 1'b1, 3'd1, 8'h05, 5'd0);
  endtask

  task automatic test_we_start();
    do_reset();
    Prog_We = 1'b1; Prog_Addr = 5'd0; Prog_Data = 8'h0A; Start = 1'b1;
    cyc();
    Prog_We = 1'b0; Start = 1'b0;
    #1;
    chk_wr("we_start", 1'b1, 3'd1, 8'h02, 5'd0);
    cyc();
    // Write attempt during RUN must be dropped.
    Prog_We = 1'b1; Prog_Addr = 5'd5; Prog_Data = 8'hC0;
    cyc();
    Prog_We = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    chk_wr("run_we_ignored", 1'b1, 3'd1, 8'h05, 5'd5);
    chk_st("run_we_busy", 1'b1, 1'b0, 5'd5, 8'd5);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    Reset = 1'b0; Prog_We = 1'b0; Prog_Addr = '0; Prog_Data = 8'h00; Start = 1'b0;
    test_reset();
    test_ldi_halt();
    test_addi_wrap();
    test_jmp();
    test_wrap_saturate_reset();
    test_we_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
